// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the boot-loadable instruction memory controller.
package imem_boot_ctrl_pkg;

    localparam int unsigned MEM_SIZE_DEF = 512;
    localparam int unsigned AW_DEF       = 9;

    // Instruction presented to the CPU whenever it is held off the memory.
    localparam logic [31:0] NOP = 32'h0;

    // Resident boot program present at power-up; all other words start at 0.
    localparam logic [31:0] BOOT_W0 = 32'h0000_0013;
    localparam logic [31:0] BOOT_W1 = 32'h0010_0093;
    localparam logic [31:0] BOOT_W2 = 32'h0020_0113;
    localparam logic [31:0] BOOT_W3 = 32'h0000_006F;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        CLEAR,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_boot_ctrl_ram.sv
// Instruction storage: asynchronous read for zero-latency fetch, synchronous write
// for the loader. Contents come up with the resident boot image and are never reset.
module imem_ram
    import imem_boot_ctrl_pkg::*;
#(
    parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
    parameter int unsigned AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [MEM_SIZE] = '{
        0: BOOT_W0,
        1: BOOT_W1,
        2: BOOT_W2,
        3: BOOT_W3,
        default: NOP
    };

    // Loader write port; the CPU side is read-only.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: serves CPU fetches from instruction memory and, on request,
// reloads the memory from a length-prefixed big-endian byte stream, zero-filling
// whatever the new image does not cover.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
    parameter int unsigned AW       = AW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        cpu_hold,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        load_done,
    output logic        load_err
);

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [23:0]   part_q, part_d;
    logic          err_q, err_d;
    logic          hold_q, ready_q, done_q;

    logic          accept;
    logic [15:0]   hdr_len;
    logic [AW:0]   ptr_next;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          addr_unused;

    imem_ram #(
        .MEM_SIZE (MEM_SIZE),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (rdata)
    );

    assign addr_unused = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};
    assign accept      = rx_valid & ready_q;
    assign hdr_len     = {len_q[15:8], rx_data};
    assign ptr_next    = ptr_q + (AW+1)'(1);

    // Next-state, datapath and memory-write decode for the loader.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        bidx_d  = bidx_q;
        part_d  = part_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = ptr_q[AW-1:0];
        wdata   = NOP;
        case (state_q)
            IDLE, ERR: begin
                if (load_start) begin
                    state_d = HDR0;
                    err_d   = 1'b0;
                end
            end
            HDR0: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    state_d     = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    len_d  = hdr_len;
                    ptr_d  = '0;
                    bidx_d = '0;
                    if (32'(hdr_len) > MEM_SIZE) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (hdr_len == '0) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (bidx_q == 2'd3) begin
                        we     = 1'b1;
                        wdata  = {part_q, rx_data};
                        ptr_d  = ptr_next;
                        bidx_d = '0;
                        if (16'(ptr_next) == len_q) begin
                            state_d = (32'(len_q) == MEM_SIZE) ? DONE : CLEAR;
                        end
                    end else begin
                        part_d = {part_q[15:0], rx_data};
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            CLEAR: begin
                we    = 1'b1;
                ptr_d = ptr_next;
                if (32'(ptr_q) == MEM_SIZE - 1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and loader registers; outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            bidx_q  <= '0;
            part_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            bidx_q  <= bidx_d;
            part_q  <= part_d;
            err_q   <= err_d;
            hold_q  <= (state_d != IDLE);
            ready_q <= (state_d == HDR0) || (state_d == HDR1) || (state_d == LOAD);
            done_q  <= (state_d == DONE);
        end
    end

    assign fetch_instr = (state_q == IDLE) ? rdata : NOP;
    assign cpu_hold    = hold_q;
    assign rx_ready    = ready_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed and randomized loads checked every cycle
// against a byte-counting reference model of the loader and memory.
module tb_imem_boot_ctrl;

    localparam int MEM = 512;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data    = 8'h0;
    logic        rx_valid   = 1'b0;
    logic        rx_ready;
    logic        load_done;
    logic        load_err;

    imem_boot_ctrl #(
        .MEM_SIZE (512),
        .AW       (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .cpu_hold    (cpu_hold),
        .load_start  (load_start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [MEM];
    bit          m_init  = 0;
    int          m_hdr   = -1;   // header bytes received so far, -1 when not in header
    int          m_pay   = -1;   // payload bytes received, -1 when not loading
    int          m_clr   = -1;   // next word to zero, -1 when not clearing
    int          m_N     = 0;
    bit          m_done  = 0;
    bit          m_errst = 0;
    bit          m_errf  = 0;
    logic [31:0] m_acc   = 32'h0;

    function automatic bit m_hold();
        return m_errst || (m_hdr >= 0) || (m_pay >= 0) || (m_clr >= 0) || m_done;
    endfunction

    function automatic bit m_ready();
        return (m_hdr >= 0) || (m_pay >= 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!m_init) begin
            for (int i = 0; i < MEM; i++) ref_mem[i] = 32'h0;
            ref_mem[0] = 32'h0000_0013;
            ref_mem[1] = 32'h0010_0093;
            ref_mem[2] = 32'h0020_0113;
            ref_mem[3] = 32'h0000_006F;
            m_init = 1;
        end
        if (!rst_n) begin
            m_hdr = -1; m_pay = -1; m_clr = -1; m_N = 0;
            m_done = 0; m_errst = 0; m_errf = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_clr >= 0) begin
            ref_mem[m_clr] = 32'h0;
            m_clr++;
            if (m_clr == MEM) begin m_clr = -1; m_done = 1; end
        end else if (m_ready() && rx_valid) begin
            if (m_hdr == 0) begin
                m_N = int'(rx_data) << 8;
                m_hdr = 1;
            end else if (m_hdr == 1) begin
                m_N = m_N + int'(rx_data);
                m_hdr = -1;
                if (m_N > MEM) begin m_errf = 1; m_errst = 1; end
                else if (m_N == 0) m_clr = 0;
                else m_pay = 0;
            end else begin
                m_acc = {m_acc[23:0], rx_data};
                m_pay++;
                if (m_pay % 4 == 0) ref_mem[m_pay/4 - 1] = m_acc;
                if (m_pay == 4 * m_N) begin
                    m_pay = -1;
                    if (m_N == MEM) m_done = 1;
                    else m_clr = m_N;
                end
            end
        end else if ((!m_hold() || m_errst) && load_start) begin
            m_errf = 0; m_errst = 0; m_hdr = 0;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int clr_cycles = 0;
    bit pin = 0;
    bit noise = 0;
    logic [7:0] tx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] exp_i;
        int bad;
        check1("cpu_hold", cpu_hold, m_hold());
        check1("rx_ready", rx_ready, m_ready());
        check1("load_done", load_done, m_done);
        check1("load_err", load_err, m_errf);
        exp_i = m_hold() ? 32'h0 : ref_mem[fetch_addr[10:2]];
        check("fetch_instr", fetch_instr, exp_i);
        bad = -1;
        for (int i = MEM - 1; i >= 0; i--)
            if (dut.u_ram.mem_q[i] !== ref_mem[i]) bad = i;
        if (bad >= 0) check($sformatf("mem[%0d]", bad), dut.u_ram.mem_q[bad], ref_mem[bad]);
        else check("mem[0]", dut.u_ram.mem_q[0], ref_mem[0]);
        if (load_done === 1'b1) done_cnt++;
        if (cpu_hold === 1'b1 && rx_ready === 1'b0 && load_done === 1'b0 && load_err === 1'b0)
            clr_cycles++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        if (!pin) fetch_addr = $urandom;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check1("hold_after_start", cpu_hold, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            rx_valid   = 1'b0;
            rx_data    = 8'($urandom);
            load_start = noise && ($urandom_range(3, 0) == 0);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            load_start = noise && ($urandom_range(3, 0) == 0);
            tick();
            t++;
        end
        if (t >= 50) check1("rx_ready_timeout", rx_ready, 1'b1);
        load_start = noise && ($urandom_range(3, 0) == 0);
        tick();
        rx_valid   = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic send_all(input int maxgap);
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), $urandom_range(maxgap, 0));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cpu_hold && t < 3000) begin
            tick();
            t++;
        end
        check1("idle_timeout", cpu_hold, 1'b0);
        tick();
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] exp);
        pin = 1;
        fetch_addr = idx * 4;
        #1;
        check(name, fetch_instr, exp);
        pin = 0;
    endtask

    task automatic push_std_image();
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0, n;

        // Reset, then resident image visible with zero latency.
        pin = 1;
        fetch_addr = 32'h0000_0008;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_word2", fetch_instr, 32'h0020_0113);
        check1("rst_hold", cpu_hold, 1'b0);
        check1("rst_ready", rx_ready, 1'b0);
        check1("rst_err", load_err, 1'b0);
        pin = 0;
        tick();

        // Two-word image at one byte per cycle.
        d0 = done_cnt; c0 = clr_cycles;
        pulse_start();
        push_std_image();
        send_all(0);
        wait_idle();
        check("std_done_count", 32'(done_cnt - d0), 32'd1);
        check("std_clear_cycles", 32'(clr_cycles - c0), 32'd510);
        lit("std_word0", 0, 32'h1234_5678);
        lit("std_word1", 1, 32'hAABB_CCDD);
        lit("std_word2", 2, 32'h0);
        lit("std_word511", 511, 32'h0);

        // Empty image: whole memory cleared.
        d0 = done_cnt; c0 = clr_cycles;
        pulse_start();
        tx_q = '{8'h00, 8'h00};
        send_all(0);
        wait_idle();
        check("zero_done_count", 32'(done_cnt - d0), 32'd1);
        check("zero_clear_cycles", 32'(clr_cycles - c0), 32'd512);
        lit("zero_word0", 0, 32'h0);
        lit("zero_word1", 1, 32'h0);

        // Same image with a 5-cycle stall after the third payload byte.
        d0 = done_cnt;
        pulse_start();
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_all(0);
        send_byte(8'h78, 5);
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_all(0);
        wait_idle();
        check("stall_done_count", 32'(done_cnt - d0), 32'd1);
        lit("stall_word0", 0, 32'h1234_5678);
        lit("stall_word1", 1, 32'hAABB_CCDD);

        // Oversized length: error, held, memory untouched, cleared by next start.
        d0 = done_cnt;
        pulse_start();
        tx_q = '{8'h02, 8'h01};
        send_all(0);
        repeat (6) tick();
        check1("err_flag", load_err, 1'b1);
        check1("err_hold", cpu_hold, 1'b1);
        check1("err_ready", rx_ready, 1'b0);
        check("err_done_count", 32'(done_cnt - d0), 32'd0);
        pulse_start();
        check1("err_cleared", load_err, 1'b0);
        tx_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_all(0);
        wait_idle();
        lit("recover_word0", 0, 32'hDEAD_BEEF);
        lit("recover_word1", 1, 32'h0);

        // Restore the two-word image, then abort a load by reset after 6 bytes.
        pulse_start();
        push_std_image();
        send_all(0);
        wait_idle();
        d0 = done_cnt;
        pulse_start();
        tx_q = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_all(0);
        rst_n = 1'b0;
        #1;
        check1("abort_hold", cpu_hold, 1'b0);
        check1("abort_ready", rx_ready, 1'b0);
        check1("abort_done", load_done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_done_count", 32'(done_cnt - d0), 32'd0);
        lit("abort_word0", 0, 32'hA1B2_C3D4);
        lit("abort_word1", 1, 32'hAABB_CCDD);

        // Random loads with gaps and ignored load_start pulses.
        noise = 1;
        for (int k = 0; k < 6; k++) begin
            d0 = done_cnt;
            n = (k == 2) ? 0 : $urandom_range(12, 1);
            pulse_start();
            tx_q.push_back(8'(n >> 8));
            tx_q.push_back(8'(n));
            for (int b = 0; b < 4 * n; b++) tx_q.push_back(8'($urandom));
            send_all(3);
            wait_idle();
            check($sformatf("rand%0d_done_count", k), 32'(done_cnt - d0), 32'd1);
        end
        noise = 0;

        // Random oversized header.
        n = $urandom_range(65535, 513);
        pulse_start();
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
        send_all(2);
        repeat (3) tick();
        check1("rand_err_flag", load_err, 1'b1);

        // Full-size image straight to DONE, no clear phase.
        d0 = done_cnt; c0 = clr_cycles;
        pulse_start();
        check1("full_err_cleared", load_err, 1'b0);
        tx_q = '{8'h02, 8'h00};
        for (int b = 0; b < 4 * MEM; b++) tx_q.push_back(8'($urandom));
        send_all(0);
        wait_idle();
        check("full_done_count", 32'(done_cnt - d0), 32'd1);
        check("full_clear_cycles", 32'(clr_cycles - c0), 32'd0);
        lit("full_word511", 511, ref_mem[511]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
